pwm_ramp_sequencer: RTL

Motor start/stop and soft-ramp sequencer between the switch controller and the pwm block. Turns single-cycle increase/decrease/start-stop requests into a saturating duty target. Slews the applied duty cycle toward that target at a fixed tick rate. Runs a start/stop state machine, so the motor never jumps straight to full duty or to zero. Its duty_cycle output drives pwm and the digit conversion path.

---
 rtl/pwm_ramp_sequencer.sv | 124 ++++++++++++
 1 files changed

// File: rtl/pwm_ramp_sequencer.sv
// Motor start/stop sequencer: turns switch pulses into a saturating duty target
// and slews the applied duty toward the current goal one code per tick.
module pwm_ramp_sequencer #(
  parameter int unsigned MAX_DUTY     = 10,
  parameter int unsigned DEFAULT_DUTY = 5,
  parameter int unsigned RAMP_DIV     = 5000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       swt_increase,
  input  logic       swt_decrease,
  input  logic       swt_start_stop,
  output logic [3:0] duty_target,
  output logic [3:0] duty_cycle,
  output logic       motor_enable,
  output logic       ramping,
  output logic [1:0] state
);

  localparam int unsigned DUTY_W = 4;
  localparam int unsigned CNT_W  = $clog2(RAMP_DIV);

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(RAMP_DIV - 1);
  localparam logic [DUTY_W-1:0] DUTY_MAX = DUTY_W'(MAX_DUTY);
  localparam logic [DUTY_W-1:0] DUTY_DEF = DUTY_W'(DEFAULT_DUTY);

  typedef enum logic [1:0] {
    ST_STOPPED   = 2'b00,
    ST_RAMP_UP   = 2'b01,
    ST_RUNNING   = 2'b10,
    ST_RAMP_DOWN = 2'b11
  } state_e;

  state_e            state_q, state_d;
  logic [DUTY_W-1:0] target_q, target_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DUTY_W-1:0] goal_c;
  logic              motor_enable_c;
  logic              ramping_c;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_STOPPED;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: start_stop wins over completion checks
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_STOPPED: begin
        if (swt_start_stop) state_d = ST_RAMP_UP;
      end
      ST_RAMP_UP: begin
        if (swt_start_stop)          state_d = ST_RAMP_DOWN;
        else if (duty_q == target_q) state_d = ST_RUNNING;
      end
      ST_RUNNING: begin
        if (swt_start_stop) state_d = ST_RAMP_DOWN;
      end
      ST_RAMP_DOWN: begin
        if (swt_start_stop)     state_d = ST_RAMP_UP;
        else if (duty_q == '0)  state_d = ST_STOPPED;
      end
      default: state_d = ST_STOPPED;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    goal_c         = '0;
    motor_enable_c = 1'b0;
    if (state_q == ST_RAMP_UP || state_q == ST_RUNNING) begin
      goal_c = target_q;
    end
    if (state_q != ST_STOPPED) begin
      motor_enable_c = 1'b1;
    end
    ramping_c = (duty_q != goal_c);
  end

  // Target saturation and tick-paced slewing; a state change restarts the tick
  always_comb begin
    target_d = target_q;
    cnt_d    = cnt_q + CNT_W'(1);
    duty_d   = duty_q;

    if (swt_increase && !swt_decrease && target_q < DUTY_MAX) begin
      target_d = target_q + DUTY_W'(1);
    end else if (swt_decrease && !swt_increase && target_q != '0) begin
      target_d = target_q - DUTY_W'(1);
    end

    if (state_d != state_q || duty_q == goal_c) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d  = '0;
      duty_d = (duty_q < goal_c) ? duty_q + DUTY_W'(1) : duty_q - DUTY_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target_q <= DUTY_DEF;
      duty_q   <= '0;
      cnt_q    <= '0;
    end else begin
      target_q <= target_d;
      duty_q   <= duty_d;
      cnt_q    <= cnt_d;
    end
  end

  assign duty_target  = target_q;
  assign duty_cycle   = duty_q;
  assign motor_enable = motor_enable_c;
  assign ramping      = ramping_c;
  assign state        = state_q;

endmodule
